// File: rtl/sr_pkg.sv
// Shared definitions for the SR excitation driver: FSM states, SR command codes, counter width.
package sr_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        CHECK = 2'd3
    } sr_state_e;

    // Command encoding is {s, r}
    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RST     = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

    // Collapses the forbidden s=r=1 code to a hold so it can never reach the flop.
    function automatic logic [1:0] sr_safe(input logic [1:0] cmd);
        return (cmd == SR_ILLEGAL) ? SR_HOLD : cmd;
    endfunction

endpackage

// File: rtl/sr_excite_lut.sv
// SR excitation table: maps (current q, wanted next q) to the {s,r} command;
// the don't-care input is driven with DC_VAL.
module sr_excite_lut
    import sr_pkg::*;
#(
    parameter logic DC_VAL = 1'b0
) (
    input  logic       q_model,
    input  logic       tgt_q,
    output logic [1:0] sr
);

    // Excitation table lookup
    always_comb begin
        sr = SR_HOLD;
        case ({q_model, tgt_q})
            2'b00:   sr = {1'b0, DC_VAL};
            2'b01:   sr = SR_SET;
            2'b10:   sr = SR_RST;
            2'b11:   sr = {DC_VAL, 1'b0};
            default: sr = SR_HOLD;
        endcase
    end

endmodule

// File: rtl/sr_excite_drv.sv
// Drives an SR flop towards requested target bits and checks y after a settle window.
// Optional macro SR_EXCITE_DRV_ERRCNT_EN adds a saturating 8-bit mismatch counter err_cnt.
module sr_excite_drv
    import sr_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int DC_VAL        = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic             s,
    output logic             r,
    input  logic             y_fb,
    output logic             done,
    output logic             mismatch,
`ifdef SR_EXCITE_DRV_ERRCNT_EN
    output logic [CNT_W-1:0] err_cnt,
`endif
    output logic             err_flag
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("sr_excite_drv: SETTLE_CYCLES must be within 1..255");
        end
        if (DC_VAL != 0 && DC_VAL != 1) begin : g_bad_dc
            $error("sr_excite_drv: DC_VAL must be 0 or 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SETTLE_LD = SETTLE_CYCLES[CNT_W-1:0];

    sr_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             tgt_q_r, tgt_q_s;
    logic             q_model_r, q_model_s;
    logic [1:0]       sr_r, sr_s;
    logic [1:0]       lut_sr_s;
    logic             err_flag_r;

    // The command is looked up at accept time so it is registered into the DRIVE cycle
    sr_excite_lut #(.DC_VAL(DC_VAL[0])) u_lut (
        .q_model (q_model_r),
        .tgt_q   (tgt_bit),
        .sr      (lut_sr_s)
    );

    // Next-state, counter and command selection
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        tgt_q_s   = tgt_q_r;
        q_model_s = q_model_r;
        sr_s      = SR_HOLD;
        case (state_r)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_q_s = tgt_bit;
                    cnt_s   = SETTLE_LD;
                    sr_s    = sr_safe(lut_sr_s);
                    state_s = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: state_s = WAIT;
            WAIT: begin
                cnt_s = cnt_r - 8'd1;
                if (cnt_r == 8'd1) begin
                    state_s = CHECK;
                end else begin
                    state_s = WAIT;
                end
            end
            CHECK: begin
                // Track the commanded value, not y_fb, so a faulty flop cannot skew later commands
                q_model_s = tgt_q_r;
                state_s   = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 8'd0;
            tgt_q_r    <= 1'b0;
            q_model_r  <= 1'b0;
            sr_r       <= SR_HOLD;
            err_flag_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            tgt_q_r    <= tgt_q_s;
            q_model_r  <= q_model_s;
            sr_r       <= sr_s;
            err_flag_r <= err_flag_r | mismatch;
        end
    end

`ifdef SR_EXCITE_DRV_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_r;

    // Saturating mismatch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else if (mismatch && err_cnt_r != 8'hFF) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

    assign tgt_ready = (state_r == IDLE);
    assign done      = (state_r == CHECK);
    assign mismatch  = (state_r == CHECK) && (y_fb != tgt_q_r);
    assign s         = sr_r[1];
    assign r         = sr_r[0];
    assign err_flag  = err_flag_r;

endmodule

// File: doc/sr_excite_drv.md
Name: sr_excite_drv

Overview:
- Drives the s/r inputs of the sr_fsm flop so that its output y reaches a requested target bit.
- Each target bit is converted to an SR command using the SR excitation table, applied for one cycle, then checked against y after a settle window.
- Sits between test or control logic and an SR flop instance. It is the stimulus and command end of the SR interface.
- Never issues s=1 and r=1 together.

Parameters:
- SETTLE_CYCLES, 1, number of hold cycles (s=r=0) between the drive cycle and the check cycle; legal range 1..255.
- DC_VAL, 0, value driven on the excitation-table don't-care input (r for 0->0, s for 1->1); legal values 0 or 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- tgt_valid  input  1  target bit offered
- tgt_bit  input  1  requested next value of y
- tgt_ready  output  1  block can accept a target; high only in IDLE
- s  output  1  set command to the flop; registered
- r  output  1  reset command to the flop; registered
- y_fb  input  1  y of the driven flop
- done  output  1  one-cycle pulse, high in the CHECK cycle
- mismatch  output  1  one-cycle pulse in CHECK when y_fb differs from the latched target
- err_flag  output  1  sticky; set on any mismatch, cleared only by rst

Behaviour:
- Reset is synchronous and active-high on clk. One clock domain only.
- rst=1 at a clk edge, from any state including mid-operation:
  - state goes to IDLE;
  - s, r, done, mismatch and err_flag go to 0;
  - q_model and the settle counter go to 0.
  - q_model=0 matches the flop's reset state s0.
- States: IDLE, DRIVE, WAIT, CHECK.
- IDLE:
  - tgt_ready=1 and s=r=0.
  - On tgt_valid=1 at an edge: latch tgt_bit into tgt_q, load the settle counter with SETTLE_CYCLES, go to DRIVE.
- DRIVE, exactly one cycle. s/r come from the excitation table on (q_model, tgt_q):
  - 0->0: s=0, r=DC_VAL
  - 0->1: s=1, r=0
  - 1->0: s=0, r=1
  - 1->1: s=DC_VAL, r=0
  - Next state is WAIT.
- WAIT:
  - s=r=0.
  - The counter decrements each cycle; go to CHECK when it reaches 1 at an edge.
  - WAIT lasts exactly SETTLE_CYCLES cycles.
- CHECK, one cycle:
  - done=1.
  - mismatch=1 if y_fb != tgt_q, and err_flag is then set at the following edge.
  - q_model is loaded with tgt_q, not y_fb.
  - Next state is IDLE.
- Latency:
  - Accept at edge E0; s/r are valid in the cycle after E0.
  - done is high in the cycle after edge E0+1+SETTLE_CYCLES.
  - Back in IDLE after edge E0+2+SETTLE_CYCLES.
  - Throughput is one target per SETTLE_CYCLES+3 cycles.
- tgt_valid while tgt_ready=0 is ignored; the target is not queued.
- A target equal to q_model still runs the full sequence (hold command), so done always follows an accept.
- s&r is never 1 in any state for any parameter value; this is an assertion for verification.
- SETTLE_CYCLES outside 1..255: elaboration error.

Optional Feature:
- Macro: SR_EXCITE_DRV_ERRCNT_EN.
- Defined:
  - adds output err_cnt, 8 bits;
  - increments in the cycle after each mismatch pulse;
  - saturates at 255;
  - cleared by rst.
- Undefined: no err_cnt port or logic; err_flag is the only error indication.

Decomposition:
- Shared package sr_pkg:
  - state encoding enum (IDLE=2'd0, DRIVE=2'd1, WAIT=2'd2, CHECK=2'd3);
  - SR command constants (SR_HOLD=2'b00, SR_RST=2'b01, SR_SET=2'b10, SR_ILLEGAL=2'b11);
  - the 8-bit counter width constant.
- One sub-module, sr_excite_lut: combinational mapping of (q_model, tgt_q, DC_VAL) to {s,r}.
  - Reusable by sr_fsm checkers and scoreboards.
- FSM, counter and registers stay in the top.

Test Plan:
- Reset then tgt_bit=1, with SETTLE_CYCLES=1 and an sr_fsm instance on y_fb:
  - s=1, r=0 for one cycle after the accept;
  - done in the third cycle after the accept;
  - mismatch=0, and y_fb=1 afterwards.
- Sequence 1,0,0,1,1 with DC_VAL=0:
  - {s,r} per drive cycle = 10, 01, 00, 10, 00;
  - no mismatch; tgt_ready low for 3 cycles per target.
- Same sequence with DC_VAL=1: {s,r} = 10, 01, 01, 10, 10.
  - Assertion s&r==0 holds throughout the run.
- y_fb tied to 0, target 1:
  - mismatch and done pulse together;
  - err_flag=1 from the next cycle and stays 1;
  - err_cnt=1 when the macro is defined.
- SETTLE_CYCLES=4:
  - done 6 cycles after the accept;
  - tgt_valid held high throughout, accepted again only when back in IDLE.
- rst asserted during WAIT:
  - next cycle in IDLE, s=r=0, done=0, err_flag=0, tgt_ready=1;
  - the following target 1 drives s=1 because q_model=0.
